instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
// - Consumer side of the program counter: walks PC (+4 per word) and issues instruction-memory reads.
// - Accepts in-order read responses and buffers them with their PCs in a small queue.
// - Presents instructions to decode over a valid/ready handshake.
// - Handles branch/jump redirects by flushing the queue and discarding stale in-flight responses.
// PARAMETERS
// - ADDR_W     32  width of PC / memory address
// - DATA_W     32  instruction word width
// - DEPTH       4  instruction queue entries (power of 2, >=2)
// - MAX_OUT     2  max outstanding memory reads (1..DEPTH)
// - RESET_PC    0  fetch address loaded on reset
// PORTS
// - clk             in   1       single clock, rising edge
// - rst             in   1       asynchronous reset, active-low (0 = reset)
// - redirect_valid  in   1       decode/execute requests new fetch address this cycle
// - redirect_pc     in   ADDR_W  target address; bits[1:0] ignored (forced 2'b00)
// - mem_req_valid   out  1       read request valid
// - mem_req_addr    out  ADDR_W  read address (word aligned)
// - mem_req_ready   in   1       memory accepts request
// - mem_rsp_valid   in   1       read data valid; responses strictly in request order
// - mem_rsp_data    in   DATA_W  read data
// - inst_valid      out  1       queue head valid
// - inst_data       out  DATA_W  queue head instruction
// - inst_pc         out  ADDR_W  PC of queue head
// - inst_ready      in   1       decode consumes head
// BEHAVIOUR
// Reset (rst=0, async):
// - fetch_pc=RESET_PC, rsp_pc=RESET_PC, outstanding=0, drop_cnt=0, queue empty, state=FETCH.
// - mem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
// - Reset mid-transaction discards everything; memory responses owed are not tracked.
// States:
// - FETCH: may issue.
// - FLUSH: drop_cnt>0, issue blocked.
// Issue (FETCH only):
// - mem_req_valid = (outstanding<MAX_OUT) && (count+outstanding<DEPTH) && !redirect_valid.
// - Request handshake: fetch_pc += 4, outstanding++.
// - mem_req_addr = fetch_pc, held stable while valid && !ready.
// Response:
// - drop_cnt>0: data discarded, drop_cnt--, outstanding--.
// - Otherwise push {mem_rsp_data, rsp_pc}, rsp_pc += 4, outstanding--.
// - Credit rule guarantees the queue never overflows; an assertion fires on push-when-full.
// Output:
// - inst_* driven from the registered queue head; pop on inst_valid && inst_ready.
// - Zero-cycle bypass is not permitted: mem_rsp to inst_valid latency is 1 cycle minimum.
// Redirect (highest priority):
// - Queue cleared (a same-cycle pop is ignored); fetch_pc = rsp_pc = {redirect_pc[ADDR_W-1:2], 2'b00}.
// - drop_cnt = outstanding(next) minus any response arriving this cycle, which is itself dropped.
// - Next state: FLUSH if drop_cnt != 0, else FETCH.
// - No request issues in the redirect cycle.
// - Redirect during FLUSH reloads drop_cnt the same way.
// FLUSH -> FETCH:
// - Transition in the cycle drop_cnt reaches 0; issuing resumes the following cycle.
// Other rules:
// - Arithmetic: PC increments are modulo 2^ADDR_W; 0xFFFFFFFC+4 wraps to 0 silently.
// - Simultaneous push+pop on a full queue is legal; count unchanged.
// - Simultaneous push+pop on an empty queue goes through the queue; no bypass.
// STRUCTURE
// - Shared header nq_defs.vh:
//   - state encodings FETCH=1'b0, FLUSH=1'b1
//   - INSTR_BYTES=4
// - Sub-module fetch_fifo: synchronous FIFO holding {pc,data}, width ADDR_W+DATA_W, depth DEPTH.
//   - Ports: push, pop, flush, full, empty, count.
// - Top level holds fetch_pc, rsp_pc, outstanding/drop counters, state FSM and credit logic.
// TESTING
// 1. Reset release, mem_req_ready=1, 1-cycle response, inst_ready=1
//    -> req addrs 0,4,8,C...; inst_pc 0,4,8 with matching data; no gaps after fill.
// 2. inst_ready=0 for 10 cycles
//    -> exactly DEPTH=4 words queued; mem_req_valid drops; no overflow; resumes in order (PCs 0..C).
// 3. Two outstanding (3-cycle latency), redirect_pc=0x103
//    -> next req addr 0x100; both stale responses dropped; first inst_pc=0x100.
// 4. Redirect in the same cycle as mem_rsp_valid and inst_ready pop
//    -> response dropped, queue empty next cycle, drop_cnt counts remaining stale reads only.
// 5. Redirect to 0xFFFFFFF8
//    -> request addrs FFFFFFF8, FFFFFFFC, 00000000; inst_pc wraps identically.
// 6. Assert rst=0 asynchronously mid-FLUSH with 2 outstanding
//    -> outputs clear immediately; after release first req addr=RESET_PC, state FETCH.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_e : fetch FSM encoding (FETCH issues reads, FLUSH drains stale responses)
//   INSTR_BYTES   : PC increment per fetched instruction word
package instr_fetch_unit_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous FIFO holding {pc, data} instruction entries for the fetch unit.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   push, wdata : write one entry (caller guarantees space unless popping)
//   pop         : remove head entry (ignored when empty)
//   flush       : drop all entries, takes priority over push/pop
//   rdata       : registered head entry
//   full, empty : occupancy flags
//   count       : number of valid entries
module instr_fetch_unit_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;

    assign do_pop = pop && !empty;

    // Storage and pointers; storage is cleared on reset so the head reads zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: walks the PC, issues word reads to instruction memory,
// buffers in-order responses with their PCs and hands them to decode.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   redirect_valid/pc        : new fetch target; flushes queue and in-flight reads
//   mem_req_valid/addr/ready : read request channel (addr word aligned)
//   mem_rsp_valid/data       : in-order read responses
//   inst_valid/data/pc/ready : instruction handshake to decode
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          DEPTH    = 4,
    parameter int unsigned          MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned ENT_W = ADDR_W + DATA_W;

    fetch_state_e      state, state_nx;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_nx;
    logic [ADDR_W-1:0] rsp_pc, rsp_pc_nx;
    logic [CNT_W-1:0]  outstanding, outstanding_nx;
    logic [CNT_W-1:0]  drop_cnt, drop_cnt_nx;

    logic [ADDR_W-1:0] redirect_tgt;
    logic              credit_ok;
    logic              req_fire;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              unused_redirect_lsbs;

    assign redirect_tgt         = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Credit check: queued plus in-flight words never exceed the queue depth.
    assign credit_ok = (outstanding < CNT_W'(MAX_OUT)) &&
                       ((SUM_W'(fifo_count) + SUM_W'(outstanding)) < SUM_W'(DEPTH));

    assign mem_req_valid = rst && (state == FETCH) && credit_ok && !redirect_valid;
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // Responses are kept only when nothing stale is owed and no redirect is in progress.
    assign push = mem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign pop  = inst_valid && inst_ready && !redirect_valid;

    // Next-state logic for PCs, counters and FSM; redirect overrides everything.
    always_comb begin
        state_nx       = state;
        fetch_pc_nx    = fetch_pc;
        rsp_pc_nx      = rsp_pc;
        drop_cnt_nx    = drop_cnt;
        outstanding_nx = outstanding + CNT_W'(req_fire) - CNT_W'(mem_rsp_valid);

        if (req_fire) begin
            fetch_pc_nx = fetch_pc + ADDR_W'(INSTR_BYTES);
        end
        if (push) begin
            rsp_pc_nx = rsp_pc + ADDR_W'(INSTR_BYTES);
        end
        if (mem_rsp_valid && (drop_cnt != '0)) begin
            drop_cnt_nx = drop_cnt - CNT_W'(1);
        end
        if ((state == FLUSH) && (drop_cnt_nx == '0)) begin
            state_nx = FETCH;
        end

        // Every read still in flight after this cycle belongs to the old path.
        if (redirect_valid) begin
            fetch_pc_nx = redirect_tgt;
            rsp_pc_nx   = redirect_tgt;
            drop_cnt_nx = outstanding_nx;
            state_nx    = (outstanding_nx != '0) ? FLUSH : FETCH;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_nx;
            fetch_pc    <= fetch_pc_nx;
            rsp_pc      <= rsp_pc_nx;
            outstanding <= outstanding_nx;
            drop_cnt    <= drop_cnt_nx;
        end
    end

    instr_fetch_unit_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({rsp_pc, mem_rsp_data}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign inst_valid = !fifo_empty;
    assign inst_pc    = head[ENT_W-1:DATA_W];
    assign inst_data  = head[DATA_W-1:0];

    // The credit rule must keep the queue from overflowing.
    assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model with configurable latency,
// scoreboard of expected {pc, data} pushed at request time and popped at decode.
module tb_instr_fetch_unit;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready = 1'b0;
    logic              mem_rsp_valid = 1'b0;
    logic [DATA_W-1:0] mem_rsp_data = '0;
    logic              inst_valid;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        int          lat;
        int          req_pct;
        int          inst_pct;
        int          cycles;
        logic [31:0] rpc;
        logic [31:0] exp_pc;
    } vec_t;

    pend_t       pend[$];
    logic [63:0] exp_q[$];
    logic [31:0] exp_fetch = '0;
    int          cyc = 0;
    int          lat = 1;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        s_req_valid = 1'b0;
    logic        s_inst_valid = 1'b0;
    vec_t        vecs[4];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0F1E_C3A5;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // One clock cycle: drive inputs at negedge, sample and score, then advance past posedge.
    task automatic step(input logic redir, input logic [31:0] rpc, input logic rreq,
                        input logic rinst, output logic popped, output logic [31:0] ppc);
        logic rsp_now;
        popped = 1'b0;
        ppc    = '0;
        @(negedge clk);
        redirect_valid = redir;
        redirect_pc    = rpc;
        mem_req_ready  = rreq;
        inst_ready     = rinst;
        rsp_now        = (pend.size() > 0) && (pend[0].due <= cyc);
        mem_rsp_valid  = rsp_now;
        mem_rsp_data   = rsp_now ? mem_word(pend[0].addr) : '0;
        #1;
        s_req_valid  = mem_req_valid;
        s_inst_valid = inst_valid;
        if (redir) chk("req_in_redirect_cycle", 64'(mem_req_valid), 64'd0);
        if (mem_req_valid) begin
            chk("req_addr", 64'(mem_req_addr), 64'(exp_fetch));
            if (mem_req_ready) begin
                pend.push_back('{addr: mem_req_addr, due: cyc + lat});
                exp_q.push_back({exp_fetch, mem_word(exp_fetch)});
                exp_fetch = exp_fetch + 32'd4;
            end
        end
        if (inst_valid && inst_ready && !redir) begin
            popped = 1'b1;
            ppc    = inst_pc;
            if (exp_q.size() == 0) begin
                chk("inst_unexpected", 64'(inst_valid), 64'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("inst_pc", 64'(inst_pc), 64'(e[63:32]));
                chk("inst_data", 64'(inst_data), 64'(e[31:0]));
            end
        end
        if (rsp_now) void'(pend.pop_front());
        if (redir) begin
            exp_q.delete();
            exp_fetch = {rpc[31:2], 2'b00};
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic wait_first_pop(input logic [31:0] exp_pc, input string name);
        logic        p;
        logic [31:0] pc;
        logic        got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            step(1'b0, '0, 1'b1, 1'b1, p, pc);
            if (p) begin
                got = 1'b1;
                chk(name, 64'(pc), 64'(exp_pc));
            end
        end
        chk({name, "_arrived"}, 64'(got), 64'd1);
    endtask

    // Step until two reads are in flight with none due this cycle, then redirect.
    task automatic redirect_with_two_out(input logic [31:0] rpc, input string name);
        logic        p;
        logic [31:0] pc;
        logic        done;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (pend.size() == 2 && pend[0].due > cyc) begin
                step(1'b1, rpc, 1'b1, 1'b1, p, pc);
                done = 1'b1;
            end else begin
                step(1'b0, '0, 1'b1, 1'b1, p, pc);
            end
        end
        chk({name, "_setup"}, 64'(done), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        p;
        logic [31:0] pc;
        int          gaps;
        logic        done;

        //                lat req% inst% cyc  redirect_pc     first inst_pc
        vecs[0] = '{1, 100, 100, 20, 32'h0000_0203, 32'h0000_0200};
        vecs[1] = '{2,  70,  60, 30, 32'h1000_0001, 32'h1000_0000};
        vecs[2] = '{3,  50,  50, 30, 32'hFFFF_FFFA, 32'hFFFF_FFF8};
        vecs[3] = '{1, 100,  30, 30, 32'h0000_0004, 32'h0000_0004};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_req_addr", 64'(mem_req_addr), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst_data", 64'(inst_data), 64'd0);
        chk("rst_inst_pc", 64'(inst_pc), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Streaming with 1-cycle memory: no bypass, then one instruction per cycle.
        lat = 1;
        step(1'b0, '0, 1'b1, 1'b1, p, pc);
        chk("first_req_no_inst", 64'(s_inst_valid), 64'd0);
        step(1'b0, '0, 1'b1, 1'b1, p, pc);
        chk("no_bypass", 64'(s_inst_valid), 64'd0);
        step(1'b0, '0, 1'b1, 1'b1, p, pc);
        chk("first_inst_pc", 64'(pc), 64'd0);
        gaps = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, '0, 1'b1, 1'b1, p, pc);
            if (!p) gaps++;
        end
        chk("stream_gaps", 64'(gaps), 64'd0);

        // Decode stall: queue fills to DEPTH and requests stop.
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0, p, pc);
        chk("stall_req_valid", 64'(s_req_valid), 64'd0);
        chk("stall_inst_valid", 64'(s_inst_valid), 64'd1);
        chk("stall_words_held", 64'(exp_q.size()), 64'(DEPTH));
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b1, p, pc);

        // Redirect with two stale reads in flight.
        lat = 3;
        redirect_with_two_out(32'h0000_0103, "redir_two_out");
        step(1'b0, '0, 1'b1, 1'b1, p, pc);
        chk("flush_blocks_req", 64'(s_req_valid), 64'd0);
        wait_first_pop(32'h0000_0100, "redir_first_pc");

        // Redirect coinciding with a response and a decode pop.
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            #1;
            if (inst_valid && pend.size() > 0 && pend[0].due <= cyc) begin
                step(1'b1, 32'h0000_2000, 1'b1, 1'b1, p, pc);
                done = 1'b1;
            end else begin
                step(1'b0, '0, 1'b1, 1'b1, p, pc);
            end
        end
        chk("coincide_setup", 64'(done), 64'd1);
        #1;
        chk("coincide_queue_empty", 64'(inst_valid), 64'd0);
        wait_first_pop(32'h0000_2000, "coincide_first_pc");

        // Table-driven random traffic phases, each closed by a redirect.
        for (int v = 0; v < 4; v++) begin
            lat = vecs[v].lat;
            for (int c = 0; c < vecs[v].cycles; c++) begin
                step(1'b0, '0, $urandom_range(99) < vecs[v].req_pct,
                     $urandom_range(99) < vecs[v].inst_pct, p, pc);
            end
            step(1'b1, vecs[v].rpc, $urandom_range(99) < vecs[v].req_pct,
                 $urandom_range(99) < vecs[v].inst_pct, p, pc);
            wait_first_pop(vecs[v].exp_pc, "table_first_pc");
            for (int c = 0; c < 6; c++) step(1'b0, '0, 1'b1, 1'b1, p, pc);
        end

        // Asynchronous reset while flushing two stale reads.
        lat = 3;
        redirect_with_two_out(32'h0000_0300, "async_rst");
        @(negedge clk);
        redirect_valid = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_req_ready  = 1'b0;
        inst_ready     = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("async_rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("async_rst_inst_pc", 64'(inst_pc), 64'd0);
        chk("async_rst_inst_data", 64'(inst_data), 64'd0);
        pend.delete();
        exp_q.delete();
        exp_fetch = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, '0, 1'b1, 1'b1, p, pc);
        chk("post_rst_req_valid", 64'(s_req_valid), 64'd1);
        wait_first_pop(32'h0000_0000, "post_rst_first_pc");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
